dcache_load_data_align: RTL

Read-side counterpart of the dcache store byte-placement logic. It takes word-lane data returned from the dcache data array or memory response, plus the per-lane byte masks of the original load. For each lane it shifts the selected byte or halfword down to bit 0 and sign- or zero-extends it. Results are delivered through a registered valid/ready stage with a skid buffer, sitting between the dcache response path and the SM writeback arbiter.

---
 rtl/dcache_load_data_align_if.sv | 31 +++
 rtl/dcache_load_data_align.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dcache_load_data_align_if.sv
// Handshake bundle between the dcache response path and the load-data aligner.
// The master drives responses and consumes results; the slave is the aligner.
interface dcache_load_data_align_if #(
  parameter int DATA_NUM   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
);
  logic                           in_valid_i;
  logic                           in_ready_o;
  logic [DATA_WIDTH*DATA_NUM-1:0] in_data_i;
  logic [4*DATA_NUM-1:0]          in_mask_i;
  logic                           in_signed_i;
  logic [TAG_WIDTH-1:0]           in_tag_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [DATA_WIDTH*DATA_NUM-1:0] out_data_o;
  logic [TAG_WIDTH-1:0]           out_tag_o;
  logic [DATA_NUM-1:0]            out_misalign_o;
  logic [15:0]                    err_cnt_o;
  logic                           err_clr_i;

  modport master (
    output in_valid_i, in_data_i, in_mask_i, in_signed_i, in_tag_i, out_ready_i, err_clr_i,
    input  in_ready_o, out_valid_o, out_data_o, out_tag_o, out_misalign_o, err_cnt_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_mask_i, in_signed_i, in_tag_i, out_ready_i, err_clr_i,
    output in_ready_o, out_valid_o, out_data_o, out_tag_o, out_misalign_o, err_cnt_o
  );
endinterface

// File: rtl/dcache_load_data_align.sv
// Load-data aligner: moves the addressed byte/halfword of each lane to bit 0,
// extends it, and delivers the result through a registered skid-buffered stage.
module dcache_load_data_align #(
  parameter int DATA_NUM   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  dcache_load_data_align_if.slave bus
);

  localparam int DW = DATA_WIDTH * DATA_NUM;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Returns {misalign, aligned_word}; inactive lanes (mask 0000) are silent zeros.
  function automatic logic [32:0] align_lane(
    input logic [31:0] word,
    input logic [3:0]  mask,
    input logic        sgn
  );
    logic [32:0] res;
    res = 33'h0_0000_0000;
    case (mask)
      4'b1111: res = {1'b0, word};
      4'b0001: res = {1'b0, {24{sgn & word[7]}},  word[7:0]};
      4'b0010: res = {1'b0, {24{sgn & word[15]}}, word[15:8]};
      4'b0100: res = {1'b0, {24{sgn & word[23]}}, word[23:16]};
      4'b1000: res = {1'b0, {24{sgn & word[31]}}, word[31:24]};
      4'b0011: res = {1'b0, {16{sgn & word[15]}}, word[15:0]};
      4'b1100: res = {1'b0, {16{sgn & word[31]}}, word[31:16]};
      4'b0000: res = 33'h0_0000_0000;
      default: res = {1'b1, 32'h0000_0000};
    endcase
    return res;
  endfunction

  logic [DW-1:0]        aligned_s;
  logic [DATA_NUM-1:0]  misalign_s;
  logic                 in_fire_s;
  logic                 out_fire_s;

  state_e               state_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [DW-1:0]        main_data_r;
  logic [TAG_WIDTH-1:0] main_tag_r;
  logic [DATA_NUM-1:0]  main_mis_r;
  logic [DW-1:0]        skid_data_r;
  logic [TAG_WIDTH-1:0] skid_tag_r;
  logic [DATA_NUM-1:0]  skid_mis_r;
  logic [15:0]          err_cnt_r;

  // Per-lane alignment and extension of the incoming response.
  always_comb begin
    logic [32:0] lane_s;
    aligned_s  = '0;
    misalign_s = '0;
    lane_s     = 33'h0_0000_0000;
    for (int i = 0; i < DATA_NUM; i++) begin
      lane_s = align_lane(bus.in_data_i[DATA_WIDTH*i +: DATA_WIDTH],
                          bus.in_mask_i[4*i +: 4], bus.in_signed_i);
      aligned_s[DATA_WIDTH*i +: DATA_WIDTH] = lane_s[31:0];
      misalign_s[i]                         = lane_s[32];
    end
  end

  assign in_fire_s  = bus.in_valid_i & in_ready_r;
  assign out_fire_s = out_valid_r & bus.out_ready_i;

  // Main/skid pipeline control; in_ready is registered so it never sees out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      main_data_r <= '0;
      main_tag_r  <= '0;
      main_mis_r  <= '0;
      skid_data_r <= '0;
      skid_tag_r  <= '0;
      skid_mis_r  <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_data_r <= aligned_s;
            main_tag_r  <= bus.in_tag_i;
            main_mis_r  <= misalign_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_data_r <= aligned_s;
            main_tag_r  <= bus.in_tag_i;
            main_mis_r  <= misalign_s;
          end else if (in_fire_s) begin
            skid_data_r <= aligned_s;
            skid_tag_r  <= bus.in_tag_i;
            skid_mis_r  <= misalign_s;
            in_ready_r  <= 1'b0;
            state_r     <= ST_FULL;
          end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            main_data_r <= skid_data_r;
            main_tag_r  <= skid_tag_r;
            main_mis_r  <= skid_mis_r;
            in_ready_r  <= 1'b1;
            state_r     <= ST_ONE;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of delivered results that carried any misaligned lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 16'h0000;
    end else if (bus.err_clr_i) begin
      err_cnt_r <= 16'h0000;
    end else if (out_fire_s && (|main_mis_r) && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

  assign bus.in_ready_o     = in_ready_r;
  assign bus.out_valid_o    = out_valid_r;
  assign bus.out_data_o     = main_data_r;
  assign bus.out_tag_o      = main_tag_r;
  assign bus.out_misalign_o = main_mis_r;
  assign bus.err_cnt_o      = err_cnt_r;

endmodule
